alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU (IDLE -> ISSUE -> RESP).
// Define ALU_ARB_TIMEOUT_EN to add the 16-cycle unacknowledged-response watchdog and sticky Timeout flag.
module alu_arbiter #(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Req_0,
    input  logic           Req_1,
    input  logic [W-1:0]   OpA_0,
    input  logic [W-1:0]   OpA_1,
    input  logic [W-1:0]   OpB_0,
    input  logic [W-1:0]   OpB_1,
    input  logic [Ops-1:0] Op_0,
    input  logic [Ops-1:0] Op_1,
    input  logic           SCIn_0,
    input  logic           SCIn_1,
    input  logic [2:0]     Imm_0,
    input  logic [2:0]     Imm_1,
    output logic           Grant_0,
    output logic           Grant_1,
    output logic           RspValid_0,
    output logic           RspValid_1,
    input  logic           RspAck_0,
    input  logic           RspAck_1,
    output logic [W-1:0]   RspOut,
    output logic           RspZero,
    output logic           RspBit,
    output logic [W-1:0]   InputA,
    output logic [W-1:0]   InputB,
    output logic [Ops-1:0] OP,
    output logic           SC_in,
    output logic [2:0]     imm,
    input  logic [W-1:0]   Out,
    input  logic           Zero,
    input  logic           OutBit,
    output logic           Timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t         state;
    logic           owner;
    logic           prio;
    logic [W-1:0]   opa_q;
    logic [W-1:0]   opb_q;
    logic [Ops-1:0] op_q;
    logic           sc_q;
    logic [2:0]     imm_q;
    logic           sel_1;
    logic           owner_ack;
    logic           issuing;

    // Requester 1 wins when it is the only one asking, or when both ask and it holds priority.
    assign sel_1     = Req_1 & (~Req_0 | prio);
    assign owner_ack = owner ? RspAck_1 : RspAck_0;
    assign issuing   = Grant_0 | Grant_1;

    // The ALU sees the latched operands only while a grant is up, zero otherwise.
    assign InputA = issuing ? opa_q : '0;
    assign InputB = issuing ? opb_q : '0;
    assign OP     = issuing ? op_q  : '0;
    assign SC_in  = issuing & sc_q;
    assign imm    = issuing ? imm_q : 3'd0;

`ifdef ALU_ARB_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       timeout_q;

    assign Timeout = timeout_q;
`else
    assign Timeout = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            prio       <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= '0;
            sc_q       <= 1'b0;
            imm_q      <= 3'd0;
            Grant_0    <= 1'b0;
            Grant_1    <= 1'b0;
            RspValid_0 <= 1'b0;
            RspValid_1 <= 1'b0;
            RspOut     <= '0;
            RspZero    <= 1'b0;
            RspBit     <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            wait_cnt   <= 4'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Req_0 | Req_1) begin
                        owner   <= sel_1;
                        opa_q   <= sel_1 ? OpA_1  : OpA_0;
                        opb_q   <= sel_1 ? OpB_1  : OpB_0;
                        op_q    <= sel_1 ? Op_1   : Op_0;
                        sc_q    <= sel_1 ? SCIn_1 : SCIn_0;
                        imm_q   <= sel_1 ? Imm_1  : Imm_0;
                        Grant_0 <= ~sel_1;
                        Grant_1 <= sel_1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    Grant_0    <= 1'b0;
                    Grant_1    <= 1'b0;
                    RspOut     <= Out;
                    RspZero    <= Zero;
                    RspBit     <= OutBit;
                    RspValid_0 <= ~owner;
                    RspValid_1 <= owner;
`ifdef ALU_ARB_TIMEOUT_EN
                    wait_cnt   <= 4'd0;
`endif
                    state      <= RESP;
                end
                RESP: begin
                    if (owner_ack) begin
                        RspValid_0 <= 1'b0;
                        RspValid_1 <= 1'b0;
                        prio       <= ~owner;
                        state      <= IDLE;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    // The sixteenth unacknowledged cycle abandons the response.
                    else if (wait_cnt == 4'd15) begin
                        RspValid_0 <= 1'b0;
                        RspValid_1 <= 1'b0;
                        prio       <= ~owner;
                        timeout_q  <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU sits on the drive port, expected responses are queued at request time.
module tb_alu_arbiter;

    localparam int W   = 8;
    localparam int OPS = 4;
    localparam logic [OPS-1:0] OP_ADD  = 4'd0;
    localparam logic [OPS-1:0] OP_SUB  = 4'd1;
    localparam logic [OPS-1:0] OP_AND  = 4'd2;
    localparam logic [OPS-1:0] OP_BXOR = 4'd3;
    localparam logic [OPS-1:0] OP_SHL  = 4'd4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         bitv;
    } alu_res_t;

    typedef struct {
        logic         owner;
        logic [W-1:0] res;
        logic         zero;
        logic         bitv;
    } exp_t;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic           Req_0, Req_1;
    logic [W-1:0]   OpA_0, OpA_1, OpB_0, OpB_1;
    logic [OPS-1:0] Op_0, Op_1;
    logic           SCIn_0, SCIn_1;
    logic [2:0]     Imm_0, Imm_1;
    logic           Grant_0, Grant_1, RspValid_0, RspValid_1;
    logic           RspAck_0, RspAck_1;
    logic [W-1:0]   RspOut;
    logic           RspZero, RspBit;
    logic [W-1:0]   InputA, InputB;
    logic [OPS-1:0] OP;
    logic           SC_in;
    logic [2:0]     imm;
    logic [W-1:0]   Out;
    logic           Zero, OutBit;
    logic           Timeout;

    exp_t           expQ[$];
    exp_t           monExp;
    int             vectors = 0;
    int             miscompares = 0;
    logic [W-1:0]   lastRes = '0;
    logic           lastZero = 1'b0;
    logic           lastBit = 1'b0;
    logic           prevValid = 1'b0;
    alu_res_t       aluOut;

    always #5 Clk = ~Clk;

    alu_arbiter #(.W(W), .Ops(OPS)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req_0(Req_0), .Req_1(Req_1),
        .OpA_0(OpA_0), .OpA_1(OpA_1), .OpB_0(OpB_0), .OpB_1(OpB_1),
        .Op_0(Op_0), .Op_1(Op_1), .SCIn_0(SCIn_0), .SCIn_1(SCIn_1),
        .Imm_0(Imm_0), .Imm_1(Imm_1),
        .Grant_0(Grant_0), .Grant_1(Grant_1),
        .RspValid_0(RspValid_0), .RspValid_1(RspValid_1),
        .RspAck_0(RspAck_0), .RspAck_1(RspAck_1),
        .RspOut(RspOut), .RspZero(RspZero), .RspBit(RspBit),
        .InputA(InputA), .InputB(InputB), .OP(OP), .SC_in(SC_in), .imm(imm),
        .Out(Out), .Zero(Zero), .OutBit(OutBit),
        .Timeout(Timeout)
    );

    // Stand-in for the shared ALU the arbiter drives.
    function automatic alu_res_t aluModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [OPS-1:0] op, input logic sc,
                                          input logic [2:0] ix);
        alu_res_t r;
        case (op)
            OP_ADD:  r.res = a + b + {{(W-1){1'b0}}, sc};
            OP_SUB:  r.res = a - b;
            OP_AND:  r.res = a & b;
            OP_BXOR: r.res = a ^ b;
            OP_SHL:  r.res = {a[W-2:0], sc};
            default: r.res = a;
        endcase
        r.zero = (r.res == '0);
        r.bitv = a[ix];
        return r;
    endfunction

    assign aluOut = aluModel(InputA, InputB, OP, SC_in, imm);
    assign Out    = aluOut.res;
    assign Zero   = aluOut.zero;
    assign OutBit = aluOut.bitv;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic applyStimulus(input int who, input logic req, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [OPS-1:0] op,
                                 input logic sc, input logic [2:0] ix);
        if (who == 0) begin
            Req_0 = req; OpA_0 = a; OpB_0 = b; Op_0 = op; SCIn_0 = sc; Imm_0 = ix;
        end else begin
            Req_1 = req; OpA_1 = a; OpB_1 = b; Op_1 = op; SCIn_1 = sc; Imm_1 = ix;
        end
    endtask

    task automatic pushExpected(input int who, input logic [W-1:0] res, input logic zero,
                                input logic bitv);
        exp_t e;
        e.owner = (who != 0);
        e.res   = res;
        e.zero  = zero;
        e.bitv  = bitv;
        expQ.push_back(e);
    endtask

    task automatic setAck(input int who, input logic v);
        if (who == 0) RspAck_0 = v;
        else RspAck_1 = v;
    endtask

    task automatic checkIdle();
        checkOutput("idle_grant0", 32'(Grant_0), 32'd0);
        checkOutput("idle_grant1", 32'(Grant_1), 32'd0);
        checkOutput("idle_valid0", 32'(RspValid_0), 32'd0);
        checkOutput("idle_valid1", 32'(RspValid_1), 32'd0);
        checkOutput("idle_rspout", 32'(RspOut), 32'd0);
        checkOutput("idle_rspzero", 32'(RspZero), 32'd0);
        checkOutput("idle_rspbit", 32'(RspBit), 32'd0);
        checkOutput("idle_inputa", 32'(InputA), 32'd0);
        checkOutput("idle_inputb", 32'(InputB), 32'd0);
        checkOutput("idle_op", 32'({OP, SC_in, imm}), 32'd0);
        checkOutput("idle_timeout", 32'(Timeout), 32'd0);
    endtask

    // One single-requester operation with exact latency checks; wrongAck pokes acks that must be ignored.
    task automatic runOp(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [OPS-1:0] op, input logic sc, input logic [2:0] ix,
                         input logic [W-1:0] expRes, input logic expZero, input int hold,
                         input bit wrongAck);
        logic g, v;
        pushExpected(who, expRes, expZero, a[ix]);
        applyStimulus(who, 1'b1, a, b, op, sc, ix);
        @(posedge Clk); #1;
        g = (who == 0) ? Grant_0 : Grant_1;
        checkOutput("op_grant", 32'(g), 32'd1);
        checkOutput("op_grant_other", 32'((who == 0) ? Grant_1 : Grant_0), 32'd0);
        checkOutput("op_inputa", 32'(InputA), 32'(a));
        checkOutput("op_inputb", 32'(InputB), 32'(b));
        checkOutput("op_opcode", 32'({OP, SC_in, imm}), 32'({op, sc, ix}));
        if (wrongAck) setAck(who, 1'b1);
        applyStimulus(who, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 3'd0);
        @(posedge Clk); #1;
        setAck(who, 1'b0);
        checkOutput("op_grant_pulse", 32'(Grant_0 | Grant_1), 32'd0);
        checkOutput("op_valid", 32'((who == 0) ? RspValid_0 : RspValid_1), 32'd1);
        checkOutput("op_drive_off", 32'(InputA), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (wrongAck) setAck(1 - who, 1'b1);
            @(posedge Clk); #1;
            v = (who == 0) ? RspValid_0 : RspValid_1;
            checkOutput("op_valid_hold", 32'(v), 32'd1);
        end
        setAck(1 - who, 1'b0);
        setAck(who, 1'b1);
        @(posedge Clk); #1;
        setAck(who, 1'b0);
        checkOutput("op_valid_drop", 32'(RspValid_0 | RspValid_1), 32'd0);
    endtask

    // Response scoreboard and mutual-exclusion monitor.
    always @(negedge Clk) begin
        if (Reset) begin
            checkOutput("grant_excl", 32'(Grant_0 & Grant_1), 32'd0);
            checkOutput("valid_excl", 32'(RspValid_0 & RspValid_1), 32'd0);
            if ((RspValid_0 | RspValid_1) && !prevValid) begin
                checkOutput("rsp_expected", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    monExp = expQ.pop_front();
                    checkOutput("rsp_owner", 32'(RspValid_1), 32'(monExp.owner));
                    checkOutput("rsp_out", 32'(RspOut), 32'(monExp.res));
                    checkOutput("rsp_zero", 32'(RspZero), 32'(monExp.zero));
                    checkOutput("rsp_bit", 32'(RspBit), 32'(monExp.bitv));
                    lastRes  = monExp.res;
                    lastZero = monExp.zero;
                    lastBit  = monExp.bitv;
                end
            end else if (RspValid_0 | RspValid_1) begin
                checkOutput("rsp_hold", 32'({RspOut, RspZero, RspBit}), 32'({lastRes, lastZero, lastBit}));
            end
        end
        prevValid = RspValid_0 | RspValid_1;
    end

    initial begin
        int cnt;
        int waited;
        logic expOwner;
        Reset = 1'b0;
        RspAck_0 = 1'b0;
        RspAck_1 = 1'b0;
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 3'd0);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 3'd0);
        repeat (2) @(posedge Clk);
        #1;
        checkIdle();
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;

        runOp(0, 8'h05, 8'h03, OP_ADD,  1'b0, 3'd0, 8'h08, 1'b0, 2, 1'b0);
        runOp(1, 8'hAA, 8'hAA, OP_BXOR, 1'b0, 3'd1, 8'h00, 1'b1, 3, 1'b1);
        runOp(0, 8'h81, 8'h00, OP_SHL,  1'b1, 3'd7, 8'h03, 1'b0, 1, 1'b0);
        runOp(1, 8'h10, 8'h10, OP_SUB,  1'b0, 3'd4, 8'h00, 1'b1, 0, 1'b0);
        runOp(1, 8'hFF, 8'h01, OP_ADD,  1'b1, 3'd0, 8'h01, 1'b0, 1, 1'b0);
        runOp(0, 8'hF0, 8'h0F, OP_AND,  1'b0, 3'd2, 8'h00, 1'b1, 2, 1'b1);

        // Reset in the middle of a response.
        pushExpected(1, 8'h30, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, 8'hF0, 8'h3C, OP_AND, 1'b0, 3'd5);
        @(posedge Clk); #1;
        checkOutput("rst_grant1", 32'(Grant_1), 32'd1);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 3'd0);
        @(posedge Clk); #1;
        checkOutput("rst_valid1", 32'(RspValid_1), 32'd1);
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        checkIdle();
        expQ.delete();
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            checkOutput("post_rst_quiet", 32'({Grant_0, Grant_1, RspValid_0, RspValid_1}), 32'd0);
        end

        // Both requesters hold Req: ownership must alternate starting at requester 0.
        applyStimulus(0, 1'b1, 8'h10, 8'h01, OP_SUB, 1'b0, 3'd4);
        applyStimulus(1, 1'b1, 8'h7F, 8'h01, OP_ADD, 1'b0, 3'd7);
        for (int k = 0; k < 4; k++) begin
            if ((k % 2) == 0) pushExpected(0, 8'h0F, 1'b0, 1'b1);
            else pushExpected(1, 8'h80, 1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            expOwner = (k % 2) != 0;
            waited = 0;
            while (!(Grant_0 | Grant_1) && waited < 10) begin
                @(posedge Clk); #1;
                waited++;
            end
            checkOutput("dual_grant_seen", 32'(Grant_0 | Grant_1), 32'd1);
            if (!(Grant_0 | Grant_1)) break;
            checkOutput("dual_latency", 32'(waited), 32'd1);
            checkOutput("dual_owner", 32'(Grant_1), 32'(expOwner));
            @(posedge Clk); #1;
            checkOutput("dual_valid", 32'(expOwner ? RspValid_1 : RspValid_0), 32'd1);
            setAck(expOwner ? 1 : 0, 1'b1);
            if (k == 3) begin
                Req_0 = 1'b0;
                Req_1 = 1'b0;
            end
            @(posedge Clk); #1;
            setAck(expOwner ? 1 : 0, 1'b0);
            checkOutput("dual_valid_drop", 32'(RspValid_0 | RspValid_1), 32'd0);
        end
        Req_0 = 1'b0;
        Req_1 = 1'b0;
        @(posedge Clk); #1;

        // Unacknowledged response: watchdog behaviour depends on the build.
        pushExpected(0, 8'h03, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 8'h01, 8'h02, OP_ADD, 1'b0, 3'd0);
        @(posedge Clk); #1;
        checkOutput("wd_grant0", 32'(Grant_0), 32'd1);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 3'd0);
        @(posedge Clk); #1;
        checkOutput("wd_valid0", 32'(RspValid_0), 32'd1);
        cnt = 0;
`ifdef ALU_ARB_TIMEOUT_EN
        while (RspValid_0 && cnt < 40) begin
            cnt++;
            @(posedge Clk); #1;
        end
        checkOutput("wd_len", 32'(cnt), 32'd16);
        checkOutput("wd_flag", 32'(Timeout), 32'd1);
        repeat (5) @(posedge Clk);
        #1;
        checkOutput("wd_sticky", 32'(Timeout), 32'd1);
        checkOutput("wd_quiet", 32'(RspValid_0 | RspValid_1), 32'd0);
`else
        while (RspValid_0 && cnt < 110) begin
            cnt++;
            @(posedge Clk); #1;
        end
        checkOutput("wd_hold_len", 32'(cnt), 32'd110);
        checkOutput("wd_flag_off", 32'(Timeout), 32'd0);
        RspAck_0 = 1'b1;
        @(posedge Clk); #1;
        RspAck_0 = 1'b0;
        checkOutput("wd_ack_drop", 32'(RspValid_0), 32'd0);
`endif
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkIdle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL sim_watchdog: got no finish, expected finish before 500000");
        $fatal(1, "[TB] simulation watchdog expired");
    end

endmodule
